// File: rtl/johnson_monitor.sv
// johnson_monitor: checks a 4-stage Johnson counter (state + one-hot decode),
// acquires lock after LOCK_CNT good transitions, flags bad samples and faults.
// Optional revolution counter is built when JOHNSON_MONITOR_REVCNT_EN is defined;
// otherwise dout_rev is tied to zero.
module johnson_monitor #(
  parameter int LOCK_CNT = 4,
  parameter int REV_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       din_q,
  input  logic [7:0]       din_j,
  input  logic             din_en,
  input  logic             din_clr,
  output logic [2:0]       dout_phase,
  output logic             dout_lock,
  output logic             dout_fault,
  output logic             dout_err,
  output logic [REV_W-1:0] dout_rev
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCK, FAULT} state_e;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  state_e     state_q, state_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic [2:0] phase_q, phase_d;
  logic       prev_valid_q, prev_valid_d;
  logic       err_q, err_d;

  logic       legal;
  logic [2:0] idx;
  logic       match;
  logic       bad;

  // Decode the Johnson state and classify the current sample
  always_comb begin
    legal = 1'b1;
    idx   = '0;
    case (din_q)
      4'b0000: idx = 3'd0;
      4'b0001: idx = 3'd1;
      4'b0011: idx = 3'd2;
      4'b0111: idx = 3'd3;
      4'b1111: idx = 3'd4;
      4'b1110: idx = 3'd5;
      4'b1100: idx = 3'd6;
      4'b1000: idx = 3'd7;
      default: legal = 1'b0;
    endcase
    match = legal && (din_j == (8'b1 << idx));
    // The previous-index reference is the last legal, matching sample
    bad   = !match || (prev_valid_q && (idx != phase_q + 3'd1));
  end

  // Next-state, good-transition counter, error pulse and phase tracking
  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    phase_d      = phase_q;
    prev_valid_d = prev_valid_q;
    err_d        = 1'b0;

    if (din_en && match) begin
      phase_d      = idx;
      prev_valid_d = 1'b1;
    end

    if (din_clr) begin
      state_d    = IDLE;
      good_cnt_d = '0;
    end else if (din_en) begin
      case (state_q)
        IDLE: begin
          if (match) begin
            state_d    = ACQ;
            good_cnt_d = '0;
          end
        end
        ACQ: begin
          if (!bad) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_q + 4'd1 == LOCK_TGT) state_d = LOCK;
          end else begin
            err_d      = 1'b1;
            good_cnt_d = '0;
            state_d    = match ? ACQ : IDLE;
          end
        end
        LOCK: begin
          if (bad) begin
            err_d   = 1'b1;
            state_d = FAULT;
          end
        end
        default: state_d = FAULT;
      endcase
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      good_cnt_q   <= '0;
      phase_q      <= '0;
      prev_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      phase_q      <= phase_d;
      prev_valid_q <= prev_valid_d;
      err_q        <= err_d;
    end
  end

`ifdef JOHNSON_MONITOR_REVCNT_EN
  logic [REV_W-1:0] rev_q, rev_d;

  // A good sample in LOCK at index 0 is necessarily a 7->0 transition
  always_comb begin
    rev_d = rev_q;
    if (din_clr)
      rev_d = '0;
    else if (din_en && state_q == LOCK && !bad && idx == 3'd0)
      rev_d = rev_q + 1'b1;
  end

  // Revolution counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rev_q <= '0;
    else       rev_q <= rev_d;
  end

  assign dout_rev = rev_q;
`else
  assign dout_rev = '0;
`endif

  assign dout_phase = phase_q;
  assign dout_lock  = (state_q == LOCK);
  assign dout_fault = (state_q == FAULT);
  assign dout_err   = err_q;

endmodule
